gpio_bus_regs: RTL and testbench
================================

# gpio_bus_regs

Memory-mapped register front end for one GPIO port, sitting between the MIPS core's data-memory bus and the `gpio_one_port` instance. It holds the direction and output-data registers that drive the port, exposes the registered input data to software, and adds per-pin edge detection with a maskable, level-sensitive interrupt line to the core. Port width matches `gpio_one_port`: N+1 pins.

## Interface
- `N`, default 15: index of the top pin; the port is N+1 bits wide, and N+1 ≤ 32.
- `i_clk`  input  1  system clock, rising-edge.
- `i_rst`  input  1  reset; synchronous, active-high.
- `i_addr`  input  3  word address of the register within the GPIO window.
- `i_we`  input  1  write strobe, one cycle per write.
- `i_re`  input  1  read strobe, one cycle per read.
- `i_wdata`  input  32  write data.
- `o_rdata`  output  32  read data, registered.
- `i_data_received`  input  N+1  pin states from `gpio_one_port.o_data_received`.
- `o_data_dir`  output  N+1  to `gpio_one_port.i_data_dir`; 1 = pin drives.
- `o_data_transmit`  output  N+1  to `gpio_one_port.i_data_transmit`.
- `o_irq`  output  1  interrupt request to the core, registered, level.

## Operation
- Register map by `i_addr`:
  - 0 DIR (R/W).
  - 1 OUT (R/W).
  - 2 IN (RO: `i_data_received`).
  - 3 SET (W: OUT |= wdata; reads 0).
  - 4 CLR (W: OUT &= ~wdata; reads 0).
  - 5 IRQ_EN (R/W).
  - 6 IRQ_STAT (R, write-1-to-clear).
  - 7 EDGE_SEL (R/W; 1 = rising, 0 = falling).
- Only `wdata[N:0]` is used. Read bits above N return 0. Writes to IN are ignored.
- `o_data_dir` is DIR and `o_data_transmit` is OUT, driven directly from the registers.
- Edge detector:
  - `prev` register holds the last sample of `i_data_received`.
  - `armed` flag is cleared by reset and set on the first clock after reset.
  - Event on bit k when `armed` is set and `prev[k]` ≠ `in[k]`, with the direction matching `EDGE_SEL[k]`.
  - An event sets `IRQ_STAT[k]` regardless of IRQ_EN.
- Conflicts:
  - An event on bit k in the same cycle as a W1C of bit k: set wins, and the bit stays 1.
  - A write to EDGE_SEL takes effect for detection on the following cycle.
- `o_irq` next = |(IRQ_STAT & IRQ_EN), computed from the register values after the current edge.
- Simultaneous `i_we` and `i_re` to any address: both happen, and `o_rdata` returns the pre-write value.
- Reset: DIR, OUT, IRQ_EN, IRQ_STAT, EDGE_SEL, `prev`, `armed`, `o_rdata` and `o_irq` all go to 0. All pins become inputs.
- Reset asserted mid-operation: a pending write is discarded and state returns to reset values on that edge.

## Timing
- Write with `i_we` high at edge k: the register is updated at edge k, and `o_data_dir` / `o_data_transmit` change right after edge k. The physical pin then follows one cycle later, from the register inside `gpio_one_pin`.
- Read with `i_re` high at edge k: `o_rdata` is valid after edge k and held until the next read or reset. No wait states.
- Pin change to IRQ_STAT:
  - The pin is sampled in `gpio_one_pin` (1 cycle).
  - The change appears on `i_data_received`, and the event registers IRQ_STAT at the next edge.
  - `o_irq` follows one edge later.
  - From `i_data_received` change to `o_irq` is therefore 2 edges.
- W1C of the last pending enabled bit at edge k: `o_irq` deasserts after edge k+1.

## Test plan
- Reset check: hold `i_rst` for 2 cycles with `i_data_received`=16'hFFFF, then release.
  - Required: all outputs 0, and reading IN returns 16'hFFFF.
  - Required: IRQ_STAT=0, i.e. no spurious edge from the armed gating.
- Port writes: write DIR=16'h00FF, then OUT=16'hA5A5, SET 16'h0100, CLR 16'h0005.
  - Required: `o_data_dir`=00FF, and `o_data_transmit` steps A5A5 → A5A5 (SET bit already 1) → A5A0.
  - Required: readback matches, and SET/CLR read 0.
- Rising edge interrupt: EDGE_SEL=16'h0001, IRQ_EN=16'h0001, toggle `i_data_received[0]` 0→1.
  - Required: IRQ_STAT=0001 one edge later, and `o_irq`=1 two edges after the change.
  - Then toggle 1→0: no new status.
  - Then W1C 0001: `o_irq` drops one edge later.
- Falling edge with masking: EDGE_SEL=0, IRQ_EN=0, bit 3 goes 1→0.
  - Required: IRQ_STAT=0008 and `o_irq` stays 0.
  - Then write IRQ_EN=0008: `o_irq`=1 one edge later.
- Set beats clear: a rising edge on bit 2 in the same cycle as a W1C of 0004.
  - Required: IRQ_STAT[2]=1 afterwards.
- Read during write and mid-op reset:
  - `i_we`+`i_re` to OUT (old value 1234, new value 5678): `o_rdata`=1234, and OUT=5678 afterwards.
  - Assert `i_rst` together with `i_we`: the write is discarded and all registers read 0.

Source files
------------

// File: rtl/gpio_bus_regs_if.sv
// Data-memory bus slice for the GPIO register window: word address,
// single-cycle write/read strobes, write data and registered read data.
interface gpio_bus_regs_if;
    // Handshake: i_we / i_re are one-cycle strobes with no ready/valid back-pressure.
    // A strobe sampled high at a rising edge is fully serviced at that edge;
    // o_rdata is valid after the read edge and held until the next read or reset.
    logic [2:0]  i_addr;
    logic        i_we;
    logic        i_re;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;

    modport master (
        output i_addr,
        output i_we,
        output i_re,
        output i_wdata,
        input  o_rdata
    );

    modport slave (
        input  i_addr,
        input  i_we,
        input  i_re,
        input  i_wdata,
        output o_rdata
    );
endinterface

// File: rtl/gpio_bus_regs.sv
// Register front end for one GPIO port: DIR/OUT/SET/CLR control, IN readback,
// per-pin edge detection with sticky W1C status and a masked level interrupt.
module gpio_bus_regs #(
    parameter int N = 15
) (
    input  logic             i_clk,
    input  logic             i_rst,
    gpio_bus_regs_if.slave   bus,
    input  logic [N:0]       i_data_received,
    output logic [N:0]       o_data_dir,
    output logic [N:0]       o_data_transmit,
    output logic             o_irq
);
    localparam int W = N + 1;

    localparam logic [2:0] ADDR_DIR      = 3'd0;
    localparam logic [2:0] ADDR_OUT      = 3'd1;
    localparam logic [2:0] ADDR_IN       = 3'd2;
    localparam logic [2:0] ADDR_SET      = 3'd3;
    localparam logic [2:0] ADDR_CLR      = 3'd4;
    localparam logic [2:0] ADDR_IRQ_EN   = 3'd5;
    localparam logic [2:0] ADDR_IRQ_STAT = 3'd6;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd7;

    logic [N:0]  dir_q;
    logic [N:0]  out_q;
    logic [N:0]  irq_en_q;
    logic [N:0]  irq_stat_q;
    logic [N:0]  edge_sel_q;
    logic [N:0]  prev_q;
    logic        armed_q;

    logic [N:0]  wd;
    logic [N:0]  edge_ev;
    logic [N:0]  out_next;
    logic [N:0]  stat_next;
    logic [31:0] rd_mux;

    if (W < 32) begin : g_unused
        logic unused_wdata;
        assign unused_wdata = ^bus.i_wdata[31:W];
    end

    always_comb begin
        wd = bus.i_wdata[N:0];

        // armed masks the first sample after reset, when prev is still 0
        edge_ev = '0;
        if (armed_q) begin
            edge_ev = (~prev_q &  i_data_received &  edge_sel_q)
                    | ( prev_q & ~i_data_received & ~edge_sel_q);
        end

        out_next = out_q;
        if (bus.i_we) begin
            case (bus.i_addr)
                ADDR_OUT: out_next = wd;
                ADDR_SET: out_next = out_q | wd;
                ADDR_CLR: out_next = out_q & ~wd;
                default:  out_next = out_q;
            endcase
        end

        // clear first, then OR in new events so a same-cycle event wins
        stat_next = irq_stat_q;
        if (bus.i_we && bus.i_addr == ADDR_IRQ_STAT) begin
            stat_next = irq_stat_q & ~wd;
        end
        stat_next = stat_next | edge_ev;

        rd_mux = '0;
        case (bus.i_addr)
            ADDR_DIR:      rd_mux[N:0] = dir_q;
            ADDR_OUT:      rd_mux[N:0] = out_q;
            ADDR_IN:       rd_mux[N:0] = i_data_received;
            ADDR_IRQ_EN:   rd_mux[N:0] = irq_en_q;
            ADDR_IRQ_STAT: rd_mux[N:0] = irq_stat_q;
            ADDR_EDGE_SEL: rd_mux[N:0] = edge_sel_q;
            default:       rd_mux      = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            dir_q       <= '0;
            out_q       <= '0;
            irq_en_q    <= '0;
            irq_stat_q  <= '0;
            edge_sel_q  <= '0;
            prev_q      <= '0;
            armed_q     <= 1'b0;
            bus.o_rdata <= '0;
            o_irq       <= 1'b0;
        end else begin
            if (bus.i_we && bus.i_addr == ADDR_DIR)      dir_q      <= wd;
            if (bus.i_we && bus.i_addr == ADDR_IRQ_EN)   irq_en_q   <= wd;
            if (bus.i_we && bus.i_addr == ADDR_EDGE_SEL) edge_sel_q <= wd;
            out_q      <= out_next;
            irq_stat_q <= stat_next;
            prev_q     <= i_data_received;
            armed_q    <= 1'b1;
            // irq lags status by one edge: uses the values held before this edge
            o_irq      <= |(irq_stat_q & irq_en_q);
            if (bus.i_re) bus.o_rdata <= rd_mux;
        end
    end

    assign o_data_dir      = dir_q;
    assign o_data_transmit = out_q;
endmodule

// File: tb/tb_gpio_bus_regs.sv
// Bench for gpio_bus_regs: directed register/edge/irq scenarios followed by
// randomized traffic, all checked against a per-cycle behavioural model.
module tb_gpio_bus_regs;
    logic        clk;
    logic        rst;
    logic [15:0] pins;
    logic [15:0] dir_o;
    logic [15:0] tx_o;
    logic        irq_o;

    int checks;
    int failures;

    gpio_bus_regs_if bus ();

    gpio_bus_regs #(.N(15)) dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .bus             (bus),
        .i_data_received (pins),
        .o_data_dir      (dir_o),
        .o_data_transmit (tx_o),
        .o_irq           (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural model: the register file as software sees it
    logic [15:0] m_reg [8];
    logic [15:0] m_prev;
    bit          m_armed;
    logic [31:0] m_rdata;
    bit          m_irq;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit we, input bit re,
                              input logic [2:0] a, input logic [31:0] wd, input logic [15:0] din);
        logic [15:0] w;
        logic [15:0] ev;
        bit          nirq;
        w = wd[15:0];
        if (r) begin
            for (int i = 0; i < 8; i++) m_reg[i] = '0;
            m_prev = '0;
            m_armed = 0;
            m_rdata = '0;
            m_irq = 0;
            return;
        end
        nirq = (m_reg[6] & m_reg[5]) != 16'h0;
        if (re) begin
            if (a == 3'd2) m_rdata = {16'h0, din};
            else if (a == 3'd3 || a == 3'd4) m_rdata = '0;
            else m_rdata = {16'h0, m_reg[a]};
        end
        ev = '0;
        for (int k = 0; k < 16; k++)
            if (m_armed && m_prev[k] != din[k] && din[k] == m_reg[7][k]) ev[k] = 1'b1;
        if (we) begin
            case (a)
                3'd0, 3'd1, 3'd5, 3'd7: m_reg[a] = w;
                3'd3: m_reg[1] = m_reg[1] | w;
                3'd4: m_reg[1] = m_reg[1] & ~w;
                3'd6: m_reg[6] = m_reg[6] & ~w;
                default: ;
            endcase
        end
        m_reg[6] = m_reg[6] | ev;
        m_prev = din;
        m_armed = 1;
        m_irq = nirq;
    endtask

    // one bus cycle: drive at negedge, step model at posedge, compare at next negedge
    task automatic cyc(input bit r, input bit we, input bit re,
                       input logic [2:0] a, input logic [31:0] wd);
        rst = r;
        bus.i_we = we;
        bus.i_re = re;
        bus.i_addr = a;
        bus.i_wdata = wd;
        @(posedge clk);
        model_step(r, we, re, a, wd, pins);
        @(negedge clk);
        rst = 0;
        bus.i_we = 0;
        bus.i_re = 0;
        check("dir", {16'h0, dir_o}, {16'h0, m_reg[0]});
        check("out", {16'h0, tx_o}, {16'h0, m_reg[1]});
        check("irq", {31'h0, irq_o}, {31'h0, m_irq});
        check("rdata", bus.o_rdata, m_rdata);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cyc(0, 1, 0, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        cyc(0, 0, 1, a, 32'h0);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 3'd0, 32'h0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1;
        pins = 16'hFFFF;
        bus.i_we = 0;
        bus.i_re = 0;
        bus.i_addr = '0;
        bus.i_wdata = '0;
        @(negedge clk);

        // reset with all pins high, then confirm no spurious edge
        cyc(1, 0, 0, 3'd0, 32'h0);
        cyc(1, 0, 0, 3'd0, 32'h0);
        check("rst_dir", {16'h0, dir_o}, 32'h0);
        check("rst_out", {16'h0, tx_o}, 32'h0);
        check("rst_irq", {31'h0, irq_o}, 32'h0);
        idle();
        rd(3'd2);
        check("rd_in", bus.o_rdata, 32'h0000_FFFF);
        rd(3'd6);
        check("rst_stat", bus.o_rdata, 32'h0);

        // port writes
        wr(3'd0, 32'hFFFF_00FF);
        check("dir_wr", {16'h0, dir_o}, 32'h00FF);
        wr(3'd1, 32'h0000_A5A5);
        check("out_wr", {16'h0, tx_o}, 32'hA5A5);
        wr(3'd3, 32'h0000_0100);
        check("out_set", {16'h0, tx_o}, 32'hA5A5);
        wr(3'd4, 32'h0000_0005);
        check("out_clr", {16'h0, tx_o}, 32'hA5A0);
        rd(3'd0); check("rb_dir", bus.o_rdata, 32'h00FF);
        rd(3'd1); check("rb_out", bus.o_rdata, 32'hA5A0);
        rd(3'd3); check("rb_set", bus.o_rdata, 32'h0);
        rd(3'd4); check("rb_clr", bus.o_rdata, 32'h0);
        wr(3'd2, 32'h0);
        rd(3'd2); check("in_ro", bus.o_rdata, 32'hFFFF);

        // rising-edge interrupt on bit 0
        wr(3'd7, 32'h0001);
        wr(3'd5, 32'h0001);
        pins = 16'hFFFE; idle();
        pins = 16'hFFFF; idle();
        check("rise_irq_early", {31'h0, irq_o}, 32'h0);
        idle();
        check("rise_irq", {31'h0, irq_o}, 32'h1);
        pins = 16'hFFFE; idle();
        rd(3'd6); check("rise_stat", bus.o_rdata, 32'h0001);
        wr(3'd6, 32'h0001);
        check("w1c_irq_hold", {31'h0, irq_o}, 32'h1);
        idle();
        check("w1c_irq_drop", {31'h0, irq_o}, 32'h0);

        // falling edge on bit 3 while masked
        wr(3'd7, 32'h0);
        wr(3'd5, 32'h0);
        pins = 16'hFFF6; idle();
        idle();
        check("mask_irq", {31'h0, irq_o}, 32'h0);
        rd(3'd6); check("fall_stat", bus.o_rdata, 32'h0008);
        wr(3'd5, 32'h0008);
        idle();
        check("unmask_irq", {31'h0, irq_o}, 32'h1);

        // rising edge on bit 2 in the same cycle as its W1C
        wr(3'd7, 32'h0004);
        pins = 16'hFFF2; idle();
        wr(3'd6, 32'hFFFF);
        pins = 16'hFFF6; wr(3'd6, 32'h0004);
        rd(3'd6); check("set_wins", bus.o_rdata, 32'h0004);

        // simultaneous read+write, then reset with a pending write
        wr(3'd1, 32'h1234);
        cyc(0, 1, 1, 3'd1, 32'h5678);
        check("rw_old", bus.o_rdata, 32'h1234);
        rd(3'd1); check("rw_new", bus.o_rdata, 32'h5678);
        cyc(1, 1, 0, 3'd0, 32'hFFFF);
        for (int a = 0; a < 8; a++) begin
            if (a != 2) begin
                rd(3'(a));
                check("rst_wr_rd", bus.o_rdata, 32'h0);
            end
        end

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) pins = pins ^ (16'h1 << $urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) pins = 16'($urandom);
            cyc($urandom_range(0, 59) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
